// File: rtl/ex_mdu_if.sv
// Request/result bundle for the ex_mdu multiply/divide unit.
// The requester drives the *_i signals and ex_mdu drives the *_o signals.
interface ex_mdu_if #(
   parameter int XLEN      = 32,
   parameter int REGADDR_W = 5
);
   // Handshake: a request is taken on a rising edge where start_i=1, flush_i=0 and the
   // unit is idle. It is never queued. done_o is a one-cycle pulse that qualifies
   // result_o/wd_o, and no acknowledge is needed. stallreq_o holds the pipeline
   // while a request is being taken or computed.
   logic                 start_i;
   logic                 flush_i;
   logic [2:0]           op_i;
   logic [XLEN-1:0]      rs1_i;
   logic [XLEN-1:0]      rs2_i;
   logic [REGADDR_W-1:0] wd_i;
   logic [XLEN-1:0]      result_o;
   logic [REGADDR_W-1:0] wd_o;
   logic                 done_o;
   logic                 busy_o;
   logic                 stallreq_o;
   logic [1:0]           state_o;

   modport master (
      output start_i, flush_i, op_i, rs1_i, rs2_i, wd_i,
      input  result_o, wd_o, done_o, busy_o, stallreq_o, state_o
   );

   modport slave (
      input  start_i, flush_i, op_i, rs1_i, rs2_i, wd_i,
      output result_o, wd_o, done_o, busy_o, stallreq_o, state_o
   );
endinterface

// File: rtl/ex_mdu.sv
// Iterative RISC-V M-extension unit (shift-add multiply, restoring divide, one bit/cycle).
// Optional macro MDU_FAST_MUL_EN: single-cycle multiplies instead of the iterative path.
module ex_mdu #(
   parameter int XLEN      = 32,
   parameter int REGADDR_W = 5
) (
   input logic      clk,
   input logic      rst,
   ex_mdu_if.slave  mdu
);
   localparam int CNT_W = $clog2(XLEN);

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_REM    = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [2:0]             op_q, op_d;
   logic                   neg_q, neg_d;
   logic [XLEN-1:0]        a_q, a_d;
   logic [2*XLEN-1:0]      acc_q, acc_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [REGADDR_W-1:0]   wd_pend_q, wd_pend_d;
   logic [REGADDR_W-1:0]   wd_out_q, wd_out_d;
   logic [XLEN-1:0]        result_q, result_d;

   logic                   rs1_signed, rs2_signed, rs1_neg, rs2_neg, neg_in;
   logic [XLEN-1:0]        mag1, mag2;
   logic                   div_zero, div_ovf;
   logic [XLEN-1:0]        skip_result;
   logic [XLEN:0]          mul_sum;
   logic [2*XLEN-1:0]      mul_next, div_next, step_acc;
   logic [XLEN:0]          rem_sh, div_diff;

   // Sign fix-up at completion; acc holds {hi,lo} product or {remainder,quotient}.
   function automatic logic [XLEN-1:0] finalize(input logic [2:0] op, input logic neg,
                                                input logic [2*XLEN-1:0] acc);
      logic [2*XLEN-1:0] full;
      logic [XLEN-1:0]   part;
      full = neg ? -acc : acc;
      part = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
      if (op[2])            return neg ? -part : part;
      else if (op == OP_MUL) return full[XLEN-1:0];
      else                   return full[2*XLEN-1:XLEN];
   endfunction

   always_comb begin
      rs1_signed  = (mdu.op_i == OP_MULH) || (mdu.op_i == OP_MULHSU) ||
                    (mdu.op_i == OP_DIV)  || (mdu.op_i == OP_REM);
      rs2_signed  = (mdu.op_i == OP_MULH) || (mdu.op_i == OP_DIV) || (mdu.op_i == OP_REM);
      rs1_neg     = rs1_signed & mdu.rs1_i[XLEN-1];
      rs2_neg     = rs2_signed & mdu.rs2_i[XLEN-1];
      mag1        = rs1_neg ? -mdu.rs1_i : mdu.rs1_i;
      mag2        = rs2_neg ? -mdu.rs2_i : mdu.rs2_i;
      // Remainder takes the dividend's sign; everything else the xor of both.
      neg_in      = (mdu.op_i[2] & mdu.op_i[1]) ? rs1_neg : (rs1_neg ^ rs2_neg);
      div_zero    = mdu.op_i[2] && (mdu.rs2_i == '0);
      div_ovf     = ((mdu.op_i == OP_DIV) || (mdu.op_i == OP_REM)) &&
                    (mdu.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (mdu.rs2_i == '1);
      skip_result = '0;
      if (div_zero)     skip_result = mdu.op_i[1] ? mdu.rs1_i : '1;
      else if (div_ovf) skip_result = mdu.op_i[1] ? '0 : mdu.rs1_i;
   end

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? a_q : {XLEN{1'b0}})};
      mul_next = {mul_sum, acc_q[XLEN-1:1]};
      rem_sh   = acc_q[2*XLEN-1:XLEN-1];
      div_diff = rem_sh - {1'b0, a_q};
      // No borrow out of the trial subtraction means the quotient bit is 1.
      div_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      step_acc = op_q[2] ? div_next : mul_next;
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      neg_d     = neg_q;
      a_d       = a_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      wd_pend_d = wd_pend_q;
      wd_out_d  = wd_out_q;
      result_d  = result_q;
      if (mdu.flush_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (mdu.start_i) begin
                  op_d      = mdu.op_i;
                  neg_d     = neg_in;
                  a_d       = mdu.op_i[2] ? mag2 : mag1;
                  acc_d     = {{XLEN{1'b0}}, (mdu.op_i[2] ? mag1 : mag2)};
                  cnt_d     = '0;
                  wd_pend_d = mdu.wd_i;
                  state_d   = S_CALC;
                  if (div_zero || div_ovf) begin
                     result_d = skip_result;
                     wd_out_d = mdu.wd_i;
                     state_d  = S_DONE;
                  end
`ifdef MDU_FAST_MUL_EN
                  else if (!mdu.op_i[2]) begin
                     result_d = finalize(mdu.op_i, neg_in,
                                         {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2});
                     wd_out_d = mdu.wd_i;
                     state_d  = S_DONE;
                  end
`endif
               end
            end
            S_CALC: begin
               acc_d = step_acc;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(XLEN-1)) begin
                  result_d = finalize(op_q, neg_q, step_acc);
                  wd_out_d = wd_pend_q;
                  state_d  = S_DONE;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         neg_q     <= 1'b0;
         a_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         wd_pend_q <= '0;
         wd_out_q  <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         neg_q     <= neg_d;
         a_q       <= a_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         wd_pend_q <= wd_pend_d;
         wd_out_q  <= wd_out_d;
         result_q  <= result_d;
      end
   end

   assign mdu.result_o   = result_q;
   assign mdu.wd_o       = wd_out_q;
   assign mdu.done_o     = (state_q == S_DONE);
   assign mdu.busy_o     = (state_q != S_IDLE);
   assign mdu.state_o    = state_q;
   assign mdu.stallreq_o = ~rst & ((mdu.start_i & (state_q == S_IDLE) & ~mdu.flush_i) |
                                   (state_q == S_CALC));
endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu (XLEN=32): arithmetic vectors, latency, flush, reset, busy-ignore.
// Build with +define+MDU_FAST_MUL_EN to check the single-cycle multiply latency.
module tb_ex_mdu;
   localparam int XLEN = 32;
   localparam int RW   = 5;
`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = XLEN + 1;
`endif
   localparam int DIV_LAT  = XLEN + 1;
   localparam int SKIP_LAT = 1;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   logic [XLEN-1:0] exp_q[$];

   ex_mdu_if #(.XLEN(XLEN), .REGADDR_W(RW)) mdu_if ();

   ex_mdu #(.XLEN(XLEN), .REGADDR_W(RW)) dut (
      .clk (clk),
      .rst (rst),
      .mdu (mdu_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Presents a request for one edge; returns #1 after the accept edge.
   task automatic issue(input string tag, input logic [2:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [RW-1:0] wd);
      @(negedge clk);
      mdu_if.start_i = 1'b1;
      mdu_if.op_i    = op;
      mdu_if.rs1_i   = a;
      mdu_if.rs2_i   = b;
      mdu_if.wd_i    = wd;
      #1;
      check({tag, "_stall"}, 64'(mdu_if.stallreq_o), 64'd1);
      @(posedge clk);
      #1;
      mdu_if.start_i = 1'b0;
      check({tag, "_busy"}, 64'(mdu_if.busy_o), 64'd1);
   endtask

   // n0 is the cycle index (accept cycle = 1) at which polling starts.
   task automatic wait_done(input string tag, input logic [RW-1:0] wd, input int lat, input int n0);
      int n;
      logic [XLEN-1:0] exp;
      n = n0;
      while (!mdu_if.done_o && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      exp = exp_q.pop_front();
      check({tag, "_lat"}, 64'(n), 64'(lat));
      check({tag, "_res"}, 64'(mdu_if.result_o), 64'(exp));
      check({tag, "_wd"}, 64'(mdu_if.wd_o), 64'(wd));
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, 64'(mdu_if.done_o), 64'd0);
      check({tag, "_hold"}, 64'(mdu_if.result_o), 64'(exp));
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [RW-1:0] wd,
                         input logic [XLEN-1:0] exp, input int lat);
      exp_q.push_back(exp);
      issue(tag, op, a, b, wd);
      wait_done(tag, wd, lat, 1);
   endtask

   task automatic count_done(input string tag, input int cycles);
      int pulses;
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (mdu_if.done_o) pulses++;
      end
      check({tag, "_nodone"}, 64'(pulses), 64'd0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      mdu_if.start_i = 1'b0;
      mdu_if.flush_i = 1'b0;
      mdu_if.op_i    = 3'd0;
      mdu_if.rs1_i   = '0;
      mdu_if.rs2_i   = '0;
      mdu_if.wd_i    = '0;
      repeat (3) @(posedge clk);

      // Reset state, with a request held during reset.
      @(negedge clk);
      mdu_if.start_i = 1'b1;
      mdu_if.rs1_i   = 32'd3;
      mdu_if.rs2_i   = 32'd4;
      #1;
      check("rst_stall", 64'(mdu_if.stallreq_o), 64'd0);
      @(posedge clk);
      #1;
      check("rst_busy", 64'(mdu_if.busy_o), 64'd0);
      check("rst_done", 64'(mdu_if.done_o), 64'd0);
      check("rst_res", 64'(mdu_if.result_o), 64'd0);
      check("rst_wd", 64'(mdu_if.wd_o), 64'd0);
      @(negedge clk);
      mdu_if.start_i = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_busy", 64'(mdu_if.busy_o), 64'd0);

      // Arithmetic vectors.
      run_op("mul_7_m3",   3'd0, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, MUL_LAT);
      run_op("mulhu_max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, MUL_LAT);
      run_op("mulh_m1",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000, MUL_LAT);
      run_op("mulhsu_m1",  3'd2, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, MUL_LAT);
      run_op("mul_6_7",    3'd0, 32'd6,        32'd7,        5'd5,  32'd42,       MUL_LAT);
      run_op("div_m7_2",   3'd4, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD, DIV_LAT);
      run_op("rem_m7_2",   3'd6, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF, DIV_LAT);
      run_op("div_7_m2",   3'd4, 32'd7,        32'hFFFFFFFE, 5'd8,  32'hFFFFFFFD, DIV_LAT);
      run_op("rem_7_m2",   3'd6, 32'd7,        32'hFFFFFFFE, 5'd9,  32'd1,        DIV_LAT);
      run_op("divu_max_1", 3'd5, 32'hFFFFFFFF, 32'd1,        5'd10, 32'hFFFFFFFF, DIV_LAT);
      run_op("divu_100_7", 3'd5, 32'd100,      32'd7,        5'd11, 32'd14,       DIV_LAT);
      run_op("divu_5_0",   3'd5, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, SKIP_LAT);
      run_op("remu_5_0",   3'd7, 32'd5,        32'd0,        5'd13, 32'd5,        SKIP_LAT);
      run_op("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        SKIP_LAT);
      run_op("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, SKIP_LAT);

      // Flush mid-divide: abort at accept+10, then a fresh request completes normally.
      issue("flush", 3'd5, 32'd100, 32'd7, 5'd16);
      repeat (8) @(posedge clk);
      @(negedge clk);
      mdu_if.flush_i = 1'b1;
      @(posedge clk);
      #1;
      check("flush_busy", 64'(mdu_if.busy_o), 64'd0);
      check("flush_done", 64'(mdu_if.done_o), 64'd0);
      check("flush_hold", 64'(mdu_if.result_o), 64'h80000000);
      @(negedge clk);
      mdu_if.flush_i = 1'b0;
      count_done("flush", 40);
      run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd17, 32'd2, DIV_LAT);

      // Flush and start together in IDLE: not accepted.
      @(negedge clk);
      mdu_if.start_i = 1'b1;
      mdu_if.flush_i = 1'b1;
      #1;
      check("fs_stall", 64'(mdu_if.stallreq_o), 64'd0);
      @(posedge clk);
      #1;
      check("fs_busy", 64'(mdu_if.busy_o), 64'd0);
      mdu_if.start_i = 1'b0;
      mdu_if.flush_i = 1'b0;

      // Start while busy is ignored; original op result and latency stand.
      exp_q.push_back(32'd14);
      issue("ign", 3'd5, 32'd100, 32'd7, 5'd18);
      repeat (3) @(posedge clk);
      @(negedge clk);
      mdu_if.start_i = 1'b1;
      mdu_if.op_i    = 3'd0;
      mdu_if.rs1_i   = 32'd1;
      mdu_if.rs2_i   = 32'd1;
      mdu_if.wd_i    = 5'd19;
      @(posedge clk);
      #1;
      mdu_if.start_i = 1'b0;
      wait_done("ign", 5'd18, DIV_LAT, 5);

      // Reset at accept+5 of a DIV clears everything and ignores start.
      issue("rst_mid", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd20);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      mdu_if.start_i = 1'b1;
      #1;
      check("rst_mid_stall", 64'(mdu_if.stallreq_o), 64'd0);
      @(posedge clk);
      #1;
      check("rst_mid_done", 64'(mdu_if.done_o), 64'd0);
      check("rst_mid_busy", 64'(mdu_if.busy_o), 64'd0);
      check("rst_mid_res", 64'(mdu_if.result_o), 64'd0);
      check("rst_mid_wd", 64'(mdu_if.wd_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      mdu_if.start_i = 1'b0;
      count_done("rst_mid", 40);
      check("rst_mid_idle", 64'(mdu_if.busy_o), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
